// File: rtl/tt_io_loopback_bist.sv
// tt_io_loopback_bist: pin-ring loopback BIST with pattern generation, latency-matched compare and error counting.
// Define TT_BIST_ERRMASK_EN to add the sticky per-pin err_mask output.
module tt_io_loopback_bist #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16,
    parameter int LOOP_LAT = 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(8'hA5)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] loop_in,
    output logic [WIDTH-1:0] pat_out,
    output logic [WIDTH-1:0] pat_oe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [LEN_W-1:0] first_err_idx
`ifdef TT_BIST_ERRMASK_EN
    ,
    output logic [WIDTH-1:0] err_mask
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DL_N = (LOOP_LAT > 0) ? LOOP_LAT : 1;
    localparam int E_W = WIDTH + LEN_W + 1;

    state_t state;
    logic [1:0] mode_q;
    logic [LEN_W-1:0] len_q, idx;
    logic [WIDTH-1:0] lfsr, lfsr_nx;
    logic [2:0] dcnt;
    logic [E_W-1:0] dl [DL_N];
    logic [E_W-1:0] cur, tap;
    logic mis, last;
    logic [CNT_W-1:0] err_nx;

    function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [LEN_W-1:0] i,
                                                 input logic [WIDTH-1:0] s);
        return (m == 2'd0) ? WIDTH'(1) << (i % WIDTH) :
               (m == 2'd1) ? WIDTH'(i) :
               (m == 2'd2) ? s : {WIDTH{i[0]}};
    endfunction

    // Each delay-line entry is {valid, expected, index}; the tap lines up with loop_in.
    assign cur     = {state == RUN, pat_out, idx};
    assign tap     = (LOOP_LAT == 0) ? cur : dl[DL_N-1];
    assign mis     = ena && tap[E_W-1] && (loop_in != tap[E_W-2 -: WIDTH]);
    assign err_nx  = (mis && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    assign lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    assign last    = idx == len_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= '0;
            len_q         <= '0;
            idx           <= '0;
            lfsr          <= SEED;
            dcnt          <= '0;
            pat_out       <= '0;
            pat_oe        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
`ifdef TT_BIST_ERRMASK_EN
            err_mask      <= '0;
`endif
            for (int k = 0; k < DL_N; k++) dl[k] <= '0;
        end else if (!ena) begin
            state   <= IDLE;
            pat_out <= '0;
            pat_oe  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            for (int k = 0; k < DL_N; k++) dl[k] <= '0;
        end else begin
            dl[0] <= cur;
            for (int k = 1; k < DL_N; k++) dl[k] <= dl[k-1];
            err_cnt <= err_nx;
            if (mis && err_cnt == '0) first_err_idx <= tap[LEN_W-1:0];
`ifdef TT_BIST_ERRMASK_EN
            if (mis) err_mask <= err_mask | (loop_in ^ tap[E_W-2 -: WIDTH]);
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_cnt       <= '0;
                        first_err_idx <= '0;
`ifdef TT_BIST_ERRMASK_EN
                        err_mask      <= '0;
`endif
                        mode_q <= mode;
                        len_q  <= len;
                        idx    <= '0;
                        lfsr   <= SEED;
                        pass   <= len == '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            pat_oe  <= '1;
                            pat_out <= pattern(mode, '0, SEED);
                        end
                    end
                end
                RUN: begin
                    if (last) begin
                        pat_out <= '0;
                        if (LOOP_LAT == 0) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pat_oe <= '0;
                            pass   <= err_nx == '0;
                        end else begin
                            state <= DRAIN;
                            dcnt  <= 3'd1;
                        end
                    end else begin
                        idx     <= idx + 1'b1;
                        lfsr    <= lfsr_nx;
                        pat_out <= pattern(mode_q, idx + 1'b1, lfsr_nx);
                    end
                end
                DRAIN: begin
                    if (dcnt == 3'(LOOP_LAT)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pat_oe <= '0;
                        pass   <= err_nx == '0;
                    end else begin
                        dcnt <= dcnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_io_loopback_bist.sv
// tb_tt_io_loopback_bist: two BIST instances (LOOP_LAT=1/CNT_W=16 and LOOP_LAT=2/CNT_W=4) on modelled loopbacks with stuck pins.
module tb_tt_io_loopback_bist;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ena_a = 1'b0, ena_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] len = '0, s0 = '0, s1 = '0;
    logic [7:0] loop_a, loop_b, pat_a, pat_b, oe_a, oe_b, fei_a, fei_b;
    logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] err_a;
    logic [3:0] err_b;
    logic [7:0] d_a = '0, d_b1 = '0, d_b2 = '0;
`ifdef TT_BIST_ERRMASK_EN
    logic [7:0] msk_a, msk_b, o_msk;
`endif

    // Pin ring model: registered loopback of the selected depth, then stuck-at-0 / stuck-at-1 pins.
    always @(posedge clk) begin
        d_a  <= pat_a;
        d_b1 <= pat_b;
        d_b2 <= d_b1;
    end
    assign loop_a = (d_a & ~s0) | s1;
    assign loop_b = (d_b2 & ~s0) | s1;

    tt_io_loopback_bist #(.WIDTH(8), .LEN_W(8), .CNT_W(16), .LOOP_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .start(start_a), .mode(mode), .len(len),
        .loop_in(loop_a), .pat_out(pat_a), .pat_oe(oe_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .first_err_idx(fei_a)
`ifdef TT_BIST_ERRMASK_EN
        , .err_mask(msk_a)
`endif
    );

    tt_io_loopback_bist #(.WIDTH(8), .LEN_W(8), .CNT_W(4), .LOOP_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .start(start_b), .mode(mode), .len(len),
        .loop_in(loop_b), .pat_out(pat_b), .pat_oe(oe_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .first_err_idx(fei_b)
`ifdef TT_BIST_ERRMASK_EN
        , .err_mask(msk_b)
`endif
    );

    bit sel_o = 1'b0;
    logic [7:0] o_pat, o_oe, o_fei;
    logic o_busy, o_done, o_pass;
    logic [15:0] o_err;
    assign o_pat  = sel_o ? pat_b : pat_a;
    assign o_oe   = sel_o ? oe_b : oe_a;
    assign o_fei  = sel_o ? fei_b : fei_a;
    assign o_busy = sel_o ? busy_b : busy_a;
    assign o_done = sel_o ? done_b : done_a;
    assign o_pass = sel_o ? pass_b : pass_a;
    assign o_err  = sel_o ? {12'h000, err_b} : err_a;
`ifdef TT_BIST_ERRMASK_EN
    assign o_msk  = sel_o ? msk_b : msk_a;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Vector i of each pattern, computed from the pattern definitions directly.
    function automatic logic [7:0] vec(input logic [1:0] m, input int i);
        logic [7:0] s;
        s = 8'hA5;
        case (m)
            2'd0: return 8'(1) << (i % 8);
            2'd1: return 8'(i);
            2'd2: begin
                for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
                return s;
            end
            default: return (i % 2 == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic run(input bit sel, input logic [1:0] m, input int n, input logic [7:0] f0,
                       input logic [7:0] f1, input int restart_at);
        int lat, sat, e, first;
        logic [7:0] msk, v, lb;
        lat = sel ? 2 : 1;
        sat = sel ? 15 : 65535;
        e = 0; first = 0; msk = '0;
        for (int i = 0; i < n; i++) begin
            v = vec(m, i);
            lb = (v & ~f0) | f1;
            if (lb != v) begin
                if (e == 0) first = i;
                if (e < sat) e++;
                msk |= lb ^ v;
            end
        end
        @(negedge clk);
        sel_o = sel; mode = m; len = n[7:0]; s0 = f0; s1 = f1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            start_a = 1'b0; start_b = 1'b0;
            chk("pat_run", o_pat, vec(m, i));
            chk("busy_run", o_busy, 1'b1);
            chk("oe_run", o_oe, 8'hFF);
            if (i == restart_at) begin
                len = 8'd1;
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            @(negedge clk);
        end
        start_a = 1'b0; start_b = 1'b0;
        if (n > 0)
            for (int j = 0; j < lat; j++) begin
                chk("busy_drain", o_busy, 1'b1);
                chk("pat_drain", o_pat, 8'h00);
                chk("done_drain", o_done, 1'b0);
                @(negedge clk);
            end
        chk("done", o_done, 1'b1);
        chk("busy_done", o_busy, 1'b0);
        chk("oe_done", o_oe, 8'h00);
        chk("pass", o_pass, e == 0);
        chk("err_cnt", o_err, e);
        chk("first_err_idx", o_fei, first);
`ifdef TT_BIST_ERRMASK_EN
        chk("err_mask", o_msk, msk);
`endif
    endtask

    initial begin
        logic [7:0] f0, f1;
        repeat (2) @(negedge clk);
        sel_o = 1'b0;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_pass", o_pass, 1'b0);
        chk("rst_pat", o_pat, 8'h00);
        chk("rst_oe", o_oe, 8'h00);
        chk("rst_err", o_err, 16'h0);
        rst_n = 1'b1; ena_a = 1'b1; ena_b = 1'b1;

        run(0, 2'd1, 10, 8'h00, 8'h00, 4);
        run(0, 2'd0, 8, 8'h08, 8'h00, -1);

        // Async reset while DONE with a nonzero count.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("areset_err", err_a, 16'h0);
        chk("areset_done", done_a, 1'b0);
        chk("areset_fei", fei_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 2'd2, 4, 8'h00, 8'h00, -1);

        // ena drop mid-run with bit 0 stuck low: vectors 1 and 3 already counted.
        @(negedge clk);
        sel_o = 1'b0; mode = 2'd1; len = 8'd20; s0 = 8'h01; s1 = 8'h00; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("pat_v5", pat_a, 8'h05);
        ena_a = 1'b0;
        @(negedge clk);
        chk("ena_busy", busy_a, 1'b0);
        chk("ena_done", done_a, 1'b0);
        chk("ena_oe", oe_a, 8'h00);
        chk("ena_pat", pat_a, 8'h00);
        chk("ena_pass", pass_a, 1'b0);
        chk("ena_err_kept", err_a, 16'd2);
        chk("ena_fei_kept", fei_a, 8'd1);
        ena_a = 1'b1;
        run(0, 2'd1, 3, 8'h00, 8'h00, -1);

        // start with ena falling the same cycle is not accepted.
        @(negedge clk);
        ena_a = 1'b0; start_a = 1'b1; len = 8'd5;
        @(negedge clk);
        start_a = 1'b0; ena_a = 1'b1;
        chk("ena_win_busy", busy_a, 1'b0);
        chk("ena_win_oe", oe_a, 8'h00);
        @(negedge clk);
        chk("ena_win_busy2", busy_a, 1'b0);

        run(0, 2'd1, 0, 8'h00, 8'h00, -1);
        run(1, 2'd3, 40, 8'hFF, 8'h00, -1);

        // Reset mid-run returns outputs to idle immediately.
        @(negedge clk);
        sel_o = 1'b1; mode = 2'd1; len = 8'd10; s0 = 8'h00; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mreset_busy", busy_b, 1'b0);
        chk("mreset_oe", oe_b, 8'h00);
        chk("mreset_pat", pat_b, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            f0 = ($urandom_range(0, 2) == 0) ? 8'(1) << $urandom_range(0, 7) : 8'h00;
            f1 = ($urandom_range(0, 3) == 0) ? 8'(1) << $urandom_range(0, 7) : 8'h00;
            run(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 24)),
                f0, f1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
